// File: rtl/alu_sequencer.sv
// alu_sequencer
// Accepts one ALU command at a time, holds its operands stable on the alu_*
// outputs toward an external combinational ALU, and returns a single response.
//   - Forwarded ops (0-3, 8-11): wait SETTLE_CYCLES cycles, then capture alu_result.
//   - MUL (op 6): internal unsigned 32x32 shift-add over 32 cycles; alu_result unused.
//   - Any other op: immediate error response.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_op, cmd_a, cmd_b, cmd_num      command opcode and operands
//   alu_opcode, alu_a, alu_b, alu_num  latched command driven to the ALU
//   alu_result                         ALU combinational result
//   rsp_valid/rsp_ready                response handshake
//   rsp_lo, rsp_hi, rsp_err            result / low product, high product, bad opcode
//   busy                               high whenever not IDLE
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [31:0] cmd_num,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] alu_num,
  output logic [4:0]  alu_opcode,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MUL,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] num_q, num_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  mul_cnt_q, mul_cnt_d;
  logic [31:0] mul_hi_q, mul_hi_d;
  logic [31:0] mul_lo_q, mul_lo_d;
  logic [31:0] rsp_lo_q, rsp_lo_d;
  logic [31:0] rsp_hi_q, rsp_hi_d;
  logic        rsp_err_q, rsp_err_d;

  logic        fwd_op;
  logic [32:0] mul_sum;
  logic [31:0] step_hi;
  logic [31:0] step_lo;

  assign fwd_op = (cmd_op[4:2] == 3'b000) || (cmd_op[4:2] == 3'b010);

  // One shift-add step: {mul_hi, mul_lo} starts as {0, b}; each step adds a to
  // the high half when the current multiplier bit is set, then shifts the whole
  // pair right. After 32 steps the pair holds the 64-bit product.
  always_comb begin
    mul_sum = {1'b0, mul_hi_q} + (mul_lo_q[0] ? {1'b0, a_q} : 33'd0);
    step_hi = mul_sum[32:1];
    step_lo = {mul_sum[0], mul_lo_q[31:1]};
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    num_d     = num_q;
    cnt_d     = cnt_q;
    mul_cnt_d = mul_cnt_q;
    mul_hi_d  = mul_hi_q;
    mul_lo_d  = mul_lo_q;
    rsp_lo_d  = rsp_lo_q;
    rsp_hi_d  = rsp_hi_q;
    rsp_err_d = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          a_d   = cmd_a;
          b_d   = cmd_b;
          num_d = cmd_num;
          if (fwd_op) begin
            state_d = SETTLE;
            cnt_d   = 4'(SETTLE_CYCLES);
          end else if (cmd_op == 5'd6) begin
            state_d   = MUL;
            mul_cnt_d = '0;
            mul_hi_d  = '0;
            mul_lo_d  = cmd_b;
          end else begin
            state_d   = DONE;
            rsp_lo_d  = '0;
            rsp_hi_d  = '0;
            rsp_err_d = 1'b1;
          end
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = DONE;
          rsp_lo_d  = alu_result;
          rsp_hi_d  = '0;
          rsp_err_d = 1'b0;
        end
      end
      MUL: begin
        mul_hi_d  = step_hi;
        mul_lo_d  = step_lo;
        mul_cnt_d = mul_cnt_q + 5'd1;
        if (mul_cnt_q == 5'd31) begin
          state_d   = DONE;
          rsp_hi_d  = step_hi;
          rsp_lo_d  = step_lo;
          rsp_err_d = 1'b0;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      num_q     <= '0;
      cnt_q     <= '0;
      mul_cnt_q <= '0;
      mul_hi_q  <= '0;
      mul_lo_q  <= '0;
      rsp_lo_q  <= '0;
      rsp_hi_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      num_q     <= num_d;
      cnt_q     <= cnt_d;
      mul_cnt_q <= mul_cnt_d;
      mul_hi_q  <= mul_hi_d;
      mul_lo_q  <= mul_lo_d;
      rsp_lo_q  <= rsp_lo_d;
      rsp_hi_q  <= rsp_hi_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign rsp_lo     = rsp_lo_q;
  assign rsp_hi     = rsp_hi_q;
  assign rsp_err    = rsp_err_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_num    = num_q;
  assign alu_opcode = op_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  localparam int unsigned S = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b, cmd_num;
  logic [31:0] alu_a, alu_b, alu_num;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_lo, rsp_hi;
  logic        rsp_err;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  alu_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_num    (cmd_num),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_num    (alu_num),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_lo     (rsp_lo),
    .rsp_hi     (rsp_hi),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Combinational ALU attached to the sequencer.
  always_comb begin
    case (alu_opcode)
      5'd0:    alu_result = alu_a & alu_b;
      5'd1:    alu_result = alu_a | alu_b;
      5'd2:    alu_result = alu_a ^ alu_b;
      5'd3:    alu_result = ~alu_a;
      5'd8:    alu_result = alu_a << alu_num[4:0];
      5'd9:    alu_result = alu_a >> alu_num[4:0];
      5'd10:   alu_result = $signed(alu_a) >>> alu_num[4:0];
      5'd11:   alu_result = (alu_a << alu_num[4:0]) | (alu_a >> (32 - int'(alu_num[4:0])));
      default: alu_result = 32'hDEADBEEF;
    endcase
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] num;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   guard;
    int   lat;
    logic stable;
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      tick();
      guard++;
    end
    check({tag, " ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_a     = v.a;
    cmd_b     = v.b;
    cmd_num   = v.num;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = ~v.op;
    cmd_a     = ~v.a;
    cmd_b     = ~v.b;
    cmd_num   = ~v.num;
    check({tag, " busy"}, busy, 1);
    lat    = 0;
    stable = 1'b1;
    while (!rsp_valid && lat < 40) begin
      if ({alu_opcode, alu_a, alu_b, alu_num} !== {v.op, v.a, v.b, v.num}) stable = 1'b0;
      tick();
      lat++;
    end
    check({tag, " alu_stable"}, stable, 1);
    check({tag, " latency"}, lat, v.lat);
    check({tag, " rsp_lo"}, rsp_lo, v.lo);
    check({tag, " rsp_hi"}, rsp_hi, v.hi);
    check({tag, " rsp_err"}, rsp_err, v.err);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, " rsp_valid_fall"}, rsp_valid, 0);
    check({tag, " idle_ready"}, cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   guard;
    int   gap;
    logic ok;
    logic seen;
    logic [31:0] r1;

    vecs[0]  = '{5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'd0,  32'hF000F000, 32'd0, 1'b0, S};
    vecs[1]  = '{5'd1,  32'h12340000, 32'h00005678, 32'd0,  32'h12345678, 32'd0, 1'b0, S};
    vecs[2]  = '{5'd2,  32'hFFFF0000, 32'h0F0F0F0F, 32'd0,  32'hF0F00F0F, 32'd0, 1'b0, S};
    vecs[3]  = '{5'd3,  32'h0000FFFF, 32'h0,        32'd0,  32'hFFFF0000, 32'd0, 1'b0, S};
    vecs[4]  = '{5'd8,  32'h00000001, 32'h0,        32'd31, 32'h80000000, 32'd0, 1'b0, S};
    vecs[5]  = '{5'd9,  32'h80000000, 32'h0,        32'd4,  32'h08000000, 32'd0, 1'b0, S};
    vecs[6]  = '{5'd10, 32'h80000000, 32'h0,        32'd4,  32'hF8000000, 32'd0, 1'b0, S};
    vecs[7]  = '{5'd11, 32'h80000001, 32'h0,        32'd4,  32'h00000018, 32'd0, 1'b0, S};
    vecs[8]  = '{5'd6,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,  32'h00000001, 32'hFFFFFFFE, 1'b0, 32};
    vecs[9]  = '{5'd6,  32'h0,        32'h5,        32'd0,  32'h0,        32'h0,        1'b0, 32};
    vecs[10] = '{5'd6,  32'h00010000, 32'h00010000, 32'd0,  32'h0,        32'h1,        1'b0, 32};
    vecs[11] = '{5'd6,  32'h12345678, 32'h10,       32'd0,  32'h23456780, 32'h1,        1'b0, 32};
    vecs[12] = '{5'd4,  32'h1234,     32'h5678,     32'd0,  32'h0,        32'h0,        1'b1, 0};
    vecs[13] = '{5'd7,  32'hFFFFFFFF, 32'h1,        32'd0,  32'h0,        32'h0,        1'b1, 0};
    vecs[14] = '{5'd12, 32'h1,        32'h1,        32'd1,  32'h0,        32'h0,        1'b1, 0};
    vecs[15] = '{5'd31, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'd3,  32'h0,        32'h0,        1'b1, 0};

    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_num = '0;
    tick();
    tick();
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_lo", rsp_lo, 0);
    check("rst rsp_hi", rsp_hi, 0);
    check("rst rsp_err", rsp_err, 0);
    check("rst busy", busy, 0);
    check("rst cmd_ready", cmd_ready, 1);
    check("rst alu_ab", {alu_a, alu_b}, 0);
    check("rst alu_num_op", {alu_num, 27'd0, alu_opcode}, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d op%0d", i, vecs[i].op));
    end

    // Unsupported opcode: response must hold while rsp_ready stays low.
    cmd_valid = 1'b1; cmd_op = 5'd4; cmd_a = 32'h77; cmd_b = 32'h88; cmd_num = 32'h0;
    tick();
    cmd_valid = 1'b0;
    check("err rsp_valid", rsp_valid, 1);
    check("err rsp_err", rsp_err, 1);
    check("err rsp_lo", rsp_lo, 0);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_lo !== 32'd0 || rsp_hi !== 32'd0 ||
          cmd_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    end
    check("err hold 10 cycles", ok, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("err release", cmd_ready, 1);

    // Reset in the middle of a multiply discards it.
    cmd_valid = 1'b1; cmd_op = 5'd6; cmd_a = 32'hFFFFFFFF; cmd_b = 32'h3; cmd_num = '0;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    check("mulrst still busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mulrst busy", busy, 0);
    check("mulrst cmd_ready", cmd_ready, 1);
    check("mulrst rsp_valid", rsp_valid, 0);
    check("mulrst alu_a", alu_a, 0);
    check("mulrst alu_opcode", alu_opcode, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    check("mulrst no response", seen, 0);
    run_vec('{5'd1, 32'h0000F000, 32'h0F000000, 32'd0, 32'h0F00F000, 32'd0, 1'b0, S}, "after_rst op1");

    // Reset wins over a handshake on the same edge.
    cmd_valid = 1'b1; cmd_op = 5'd0; cmd_a = 32'hFFFF; cmd_b = 32'hFFFF;
    reset = 1'b1;
    tick();
    reset = 1'b0; cmd_valid = 1'b0;
    check("rst vs accept busy", busy, 0);
    check("rst vs accept alu_a", alu_a, 0);

    // A one-cycle pulse while busy is not accepted.
    cmd_valid = 1'b1; cmd_op = 5'd0; cmd_a = 32'hFFFFFFFF; cmd_b = 32'h12345678; cmd_num = '0;
    tick();
    cmd_op = 5'd3; cmd_a = 32'h55;
    tick();
    cmd_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      tick();
      guard++;
    end
    check("pulse first rsp_lo", rsp_lo, 32'h12345678);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    tick();
    check("pulse not accepted", busy, 0);

    // A held request is taken on the first IDLE cycle: S+2 spacing.
    // rsp_ready stays high throughout, which must be ignored outside DONE.
    cmd_valid = 1'b1; cmd_op = 5'd1; cmd_a = 32'h0000000F; cmd_b = 32'h000000F0; cmd_num = '0;
    rsp_ready = 1'b1;
    tick();
    cmd_op = 5'd2; cmd_a = 32'hAAAA0000; cmd_b = 32'h0000AAAA;
    gap = 0;
    r1  = '0;
    seen = 1'b0;
    do begin
      if (rsp_valid) begin
        r1   = rsp_lo;
        seen = 1'b1;
      end
      tick();
      gap++;
    end while (alu_opcode != 5'd2 && gap < 20);
    cmd_valid = 1'b0;
    check("held first rsp seen", seen, 1);
    check("held first rsp_lo", r1, 32'h000000FF);
    check("held accept spacing", gap, S + 2);
    check("held alu_a", alu_a, 32'hAAAA0000);
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      tick();
      guard++;
    end
    check("held second latency", guard, S);
    check("held second rsp_lo", rsp_lo, 32'hAAAAAAAA);
    tick();
    rsp_ready = 1'b0;
    check("held final idle", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1, meaning the number of cycles the ALU inputs are held stable before the result is captured; legal range 1..15.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port cmd_valid  input  1  command present.
REQ-005 The block SHALL have port cmd_ready  output  1  the block accepts a command this cycle.
REQ-006 The block SHALL have port cmd_op  input  5  operation code.
REQ-007 The block SHALL have port cmd_a, cmd_b, cmd_num  input  32 each  operands and shift/rotate count.
REQ-008 The block SHALL have port alu_a, alu_b, alu_num  output  32 each  operands driven to the combinational ALU.
REQ-009 The block SHALL have port alu_opcode  output  5  opcode driven to the ALU.
REQ-010 The block SHALL have port alu_result  input  32  ALU combinational result.
REQ-011 The block SHALL have port rsp_valid  output  1  response present.
REQ-012 The block SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-013 The block SHALL have port rsp_lo  output  32  result, or low product word.
REQ-014 The block SHALL have port rsp_hi  output  32  high product word; 0 for non-multiply.
REQ-015 The block SHALL have port rsp_err  output  1  unsupported opcode.
REQ-016 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, SETTLE, MUL, DONE.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted on the edge where cmd_valid && cmd_ready.
REQ-019 On acceptance, cmd_op/cmd_a/cmd_b/cmd_num SHALL be latched into internal registers; later changes on cmd_* SHALL have no effect until the next acceptance.
REQ-020 Forwarded opcodes are 0-3 (AND, OR, XOR, NOT) and 8-11 (SHL, SHR, SAR, ROL); on acceptance of one, the next state SHALL be SETTLE with a down-counter loaded to SETTLE_CYCLES.
REQ-021 alu_a/alu_b/alu_num/alu_opcode SHALL be driven directly from the latched registers in every state, so they remain stable from the edge after acceptance until the next acceptance.
REQ-022 In SETTLE the counter SHALL decrement each cycle; on the edge where it is 1, alu_result SHALL be captured into rsp_lo, rsp_hi SHALL be set to 0, rsp_err to 0, and the next state SHALL be DONE. rsp_valid therefore rises exactly SETTLE_CYCLES edges after the acceptance edge.
REQ-023 Opcode 6 (MUL) SHALL go to MUL: an unsigned radix-2 shift-add of a*b over exactly 32 cycles, with no use of alu_result; the 64-bit product SHALL be loaded into {rsp_hi, rsp_lo} on the 32nd edge after acceptance, with the next state DONE.
REQ-024 Any other opcode (4, 5, 7, 12-31) SHALL go directly to DONE on the acceptance edge, with rsp_lo=0, rsp_hi=0 and rsp_err=1.
REQ-025 In DONE, rsp_valid SHALL be 1 and rsp_lo/rsp_hi/rsp_err SHALL hold stable until rsp_ready is sampled high; on that edge the state SHALL return to IDLE and rsp_valid SHALL fall.
REQ-026 rsp_valid SHALL be 0 in every state except DONE; rsp_ready outside DONE SHALL be ignored.
REQ-027 Back-to-back operation: the minimum spacing between acceptances SHALL be SETTLE_CYCLES+2 cycles for forwarded ops, with one IDLE cycle always between the DONE handshake and the next acceptance.
REQ-028 A cmd_valid that is high while busy SHALL be neither accepted nor lost; the requester must hold it until cmd_ready.

Reset
REQ-029 reset sampled high on any edge SHALL force IDLE and zero the operand, opcode, counter, multiplier and response registers. After that edge: rsp_valid=0, rsp_lo=0, rsp_hi=0, rsp_err=0, busy=0, cmd_ready=1, and all alu_* outputs=0.
REQ-030 reset SHALL override all other inputs, including a handshake in the same cycle. An in-flight SETTLE or MUL operation SHALL be discarded with no response.

Verification
REQ-031 With SETTLE_CYCLES=1, op=0, a=0xF0F0F0F0, b=0xFF00FF00 and the ALU model attached -> rsp_valid 1 edge after acceptance, rsp_lo=0xF000F000, rsp_hi=0, rsp_err=0.
REQ-032 With SETTLE_CYCLES=3, op=11, a=0x80000001, num=4 -> alu_* stable for 3 cycles, rsp_lo=0x00000018, rsp_valid on the 3rd edge.
REQ-033 op=6, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 32 edges rsp_hi=0xFFFFFFFE and rsp_lo=0x00000001; a=0, b=5 -> product 0.
REQ-034 op=4 -> rsp_valid on the edge after acceptance, rsp_err=1, rsp_lo=0; rsp_ready held low for 10 cycles -> outputs unchanged, cmd_ready=0 throughout.
REQ-035 Reset asserted at MUL iteration 16 -> IDLE on the next edge, no rsp_valid; a new op=1 command then completes with the correct result.
REQ-036 A cmd_valid pulse while busy -> not accepted; the same command held high is accepted on the first IDLE cycle.
